output_sel_scheduler: RTL and testbench
=======================================

// Module: output_sel_scheduler
//
// PURPOSE
// - Time-sequences the 6-bit select of the 3:1 output MUX. It steps through a programmable table of
//   {select, dwell} entries, so that one DAC/monitor channel is time-shared between in0..in2.
// - The host loads the table, then pulses start; the block drives sel for the programmed dwell of
//   each entry, either once or looping, and reports progress.
//
// PARAMETERS
// - N_STEPS    4    table depth in entries; must be a power of 2, min 2.
// - DWELL_W    16   dwell counter width; one entry lasts 1..2^DWELL_W-1 clk cycles.
// - BLANK_CYC  2    blank length in cycles per entry; used only with the optional feature.
//
// PORTS
// - clk        in   1            system clock; all logic on posedge.
// - rst_n      in   1            synchronous reset, active-low.
// - start      in   1            pulse; begins the sequence at entry 0 (honoured in IDLE only).
// - stop       in   1            pulse; aborts the sequence and returns to IDLE.
// - loop_en    in   1            1: wrap from the last entry to entry 0. 0: single pass.
// - last_idx   in   log2(N)      index of the final active entry; sampled on start.
// - cfg_we     in   1            table write strobe.
// - cfg_addr   in   log2(N)      table write address.
// - cfg_sel    in   6            select value to store.
// - cfg_dwell  in   DWELL_W      dwell to store; 0 is treated as 1.
// - sel        out  6            registered select, drives the MUX sel input.
// - step_idx   out  log2(N)      index of the entry currently driving sel.
// - busy       out  1            1 while in RUN.
// - step_stb   out  1            1-cycle pulse on the first cycle of each new entry.
// - done       out  1            1-cycle pulse when a single pass completes.
// - blank      out  1            switch-blanking flag (optional feature).
//
// BEHAVIOUR
// - Reset (rst_n=0 at posedge):
//   - Outputs: sel=0, step_idx=0, busy=0, step_stb=0, done=0, blank=0.
//   - State=IDLE, dwell counter=0.
//   - Table contents are also cleared to {sel=0, dwell=1}.
//   - Reset in mid-RUN aborts immediately on the same edge.
// - Table write: on posedge with cfg_we=1, the addressed entry is updated.
//   - Writes are allowed in any state.
//   - A write to the entry currently dwelling does not change its running count or sel.
//   - The new value is used the next time that entry is loaded.
// - FSM has two states, IDLE and RUN.
//   - IDLE, start=1, stop=0: on the next edge, load entry 0 (sel<=tab[0].sel, cnt<=max(tab[0].dwell,1),
//     step_idx<=0) and latch last_idx. Then busy=1, step_stb=1, state=RUN. Latency: start to new sel is 1 cycle.
//   - RUN: cnt decrements by 1 each cycle. Entry k therefore holds sel for exactly max(dwell_k,1) cycles.
//   - RUN, cnt==1, step_idx<last: load entry step_idx+1 on the next edge and pulse step_stb.
//   - RUN, cnt==1, step_idx==last, loop_en=1: load entry 0 and pulse step_stb. No gap cycle.
//   - RUN, cnt==1, step_idx==last, loop_en=0: go to IDLE, busy=0, done=1 for one cycle.
//     sel and step_idx hold their last values.
//   - stop=1 in any state: go to IDLE on the next edge. sel and step_idx hold, busy=0, no done pulse.
//     stop has priority over start and over the entry advance.
//   - start in RUN is ignored. start and stop together in IDLE: stay in IDLE.
//   - loop_en is sampled at each wrap decision. last_idx is not re-sampled during RUN.
// - sel values of 3..63 are passed through unmodified; the MUX holds its output for those values.
// - step_stb and done are never high in the same cycle.
//
// CONFIGURATION
// - SEL_SCHED_BLANK_EN defined: blank=1 during the first min(BLANK_CYC, entry length) cycles of every
//   loaded entry, including re-entry on a wrap. A per-entry blank counter is reset on each load.
//   - blank is forced to 0 in IDLE and on stop.
//   - blank is aligned with sel; the consumer adds the MUX's 1-cycle latency.
// - SEL_SCHED_BLANK_EN undefined: blank is tied to 0. No blank counter logic is synthesised.
//   BLANK_CYC is ignored.
//
// TESTING
// - Single pass, no loop:
//   - Stimulus: N=4; table {0,3},{1,1},{2,2}; last_idx=2; loop_en=0; pulse start.
//   - Response: sel=0,0,0,1,2,2 over 6 cycles; step_stb on cycles 1,4,5; done on cycle 7;
//     sel stays 2 after done.
// - Zero dwell and wrap:
//   - Stimulus: entry0 dwell=0, entry1 dwell=2, last_idx=1, loop_en=1.
//   - Response: sel pattern 0,1,1 repeating with no gap cycles; done never pulses.
// - Abort and restart:
//   - Stop: pulse stop 5 cycles into a dwell of 10 -> busy=0 on the next cycle, sel holds, no done.
//   - Start plus stop: a same-cycle start+stop in IDLE -> stays in IDLE.
// - Write to the live entry:
//   - Stimulus: write entry1 dwell=7 while entry1 is running with dwell 3.
//   - Response: the current pass lasts 3 cycles; the next visit lasts 7 cycles.
// - Reset mid-RUN: drop rst_n for 1 cycle during entry 2 -> all outputs 0 at that edge;
//   the table reads back as {0,1}.
// - With SEL_SCHED_BLANK_EN and BLANK_CYC=2:
//   - Dwells 5 and 1: blank=1,1,0,0,0 then 1.
//   - Without the macro: blank is constantly 0.

Source files
------------

// File: rtl/output_sel_scheduler.sv
// Sequencer for the 3:1 output MUX select: steps a programmable {sel, dwell} table, once or looping.
// Optional switch-blanking flag is built only when SEL_SCHED_BLANK_EN is defined.
module output_sel_scheduler #(
  parameter int unsigned N_STEPS   = 4,
  parameter int unsigned DWELL_W   = 16,
  parameter int unsigned BLANK_CYC = 2,
  localparam int unsigned IDX_W    = $clog2(N_STEPS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_en,
  input  logic [IDX_W-1:0]   last_idx,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_addr,
  input  logic [5:0]         cfg_sel,
  input  logic [DWELL_W-1:0] cfg_dwell,
  output logic [5:0]         sel,
  output logic [IDX_W-1:0]   step_idx,
  output logic               busy,
  output logic               step_stb,
  output logic               done,
  output logic               blank
);

  typedef enum logic {IDLE, RUN} state_t;

  if (N_STEPS < 2 || (N_STEPS & (N_STEPS - 1)) != 0) begin : g_chk_n
    $error("N_STEPS must be a power of 2 and at least 2");
  end
  if (DWELL_W < 1 || BLANK_CYC >= 65536) begin : g_chk_w
    $error("DWELL_W must be >= 1 and BLANK_CYC below 65536");
  end

  state_t             state;
  logic [DWELL_W-1:0] cnt;
  logic [IDX_W-1:0]   last_q;
  logic [5:0]         tab_sel   [N_STEPS];
  logic [DWELL_W-1:0] tab_dwell [N_STEPS];

  logic               load_c;
  logic [IDX_W-1:0]   load_idx_c;
  logic [DWELL_W-1:0] load_dwell_c;
  logic               cnt_last_c;

  assign cnt_last_c = (cnt == DWELL_W'(1));

  // Decide whether an entry is loaded on the coming edge, and which one.
  always_comb begin
    load_c       = 1'b0;
    load_idx_c   = '0;
    load_dwell_c = '0;
    if (state == IDLE) begin
      load_c = start && !stop;
    end else if (!stop && cnt_last_c) begin
      if (step_idx != last_q) begin
        load_c     = 1'b1;
        load_idx_c = step_idx + IDX_W'(1);
      end else begin
        load_c = loop_en;
      end
    end
    load_dwell_c = (tab_dwell[load_idx_c] == '0) ? DWELL_W'(1) : tab_dwell[load_idx_c];
  end

  // Table, FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      last_q   <= '0;
      sel      <= '0;
      step_idx <= '0;
      busy     <= 1'b0;
      step_stb <= 1'b0;
      done     <= 1'b0;
      for (int i = 0; i < int'(N_STEPS); i++) begin
        tab_sel[i]   <= '0;
        tab_dwell[i] <= DWELL_W'(1);
      end
    end else begin
      step_stb <= 1'b0;
      done     <= 1'b0;
      if (cfg_we) begin
        tab_sel[cfg_addr]   <= cfg_sel;
        tab_dwell[cfg_addr] <= cfg_dwell;
      end
      if (state == IDLE && start && !stop) begin
        last_q <= last_idx;
      end
      if (load_c) begin
        state    <= RUN;
        sel      <= tab_sel[load_idx_c];
        step_idx <= load_idx_c;
        cnt      <= load_dwell_c;
        busy     <= 1'b1;
        step_stb <= 1'b1;
      end else if (state == RUN) begin
        if (stop) begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end else if (cnt_last_c) begin
          // End of a single pass: sel and step_idx keep their last values.
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          cnt   <= '0;
        end else begin
          cnt <= cnt - DWELL_W'(1);
        end
      end
    end
  end

`ifdef SEL_SCHED_BLANK_EN
  localparam int unsigned BLK_W = (BLANK_CYC < 2) ? 1 : $clog2(BLANK_CYC + 1);
  localparam int unsigned BLK_RELOAD = (BLANK_CYC > 0) ? BLANK_CYC - 1 : 0;

  logic [BLK_W-1:0] bcnt;

  // bcnt holds the number of blank cycles still owed after the current one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blank <= 1'b0;
      bcnt  <= '0;
    end else if (load_c) begin
      blank <= (BLANK_CYC != 0);
      bcnt  <= BLK_W'(BLK_RELOAD);
    end else if (state != RUN || stop || cnt_last_c) begin
      blank <= 1'b0;
      bcnt  <= '0;
    end else if (bcnt != '0) begin
      bcnt  <= bcnt - BLK_W'(1);
    end else begin
      blank <= 1'b0;
    end
  end
`else
  always_ff @(posedge clk) begin
    blank <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_output_sel_scheduler.sv
// Directed bench for output_sel_scheduler (default parameters); blank expectations follow SEL_SCHED_BLANK_EN.
module tb_output_sel_scheduler;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, loop_en, cfg_we;
  logic [1:0]  last_idx, cfg_addr, step_idx;
  logic [5:0]  cfg_sel, sel;
  logic [15:0] cfg_dwell;
  logic        busy, step_stb, done, blank;

  int n_cmp = 0;
  int n_bad = 0;

  output_sel_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
    .last_idx(last_idx), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_sel(cfg_sel),
    .cfg_dwell(cfg_dwell), .sel(sel), .step_idx(step_idx), .busy(busy),
    .step_stb(step_stb), .done(done), .blank(blank)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [5:0] s, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_sel = s; cfg_dwell = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  function automatic logic blk(input logic b);
`ifdef SEL_SCHED_BLANK_EN
    return b;
`else
    return 1'b0 & b;
`endif
  endfunction

  initial begin
    logic [5:0] e_sel1  [7] = '{0, 0, 0, 1, 2, 2, 2};
    logic [1:0] e_idx1  [7] = '{0, 0, 0, 1, 2, 2, 2};
    logic       e_stb1  [7] = '{1, 0, 0, 1, 1, 0, 0};
    logic       e_done1 [7] = '{0, 0, 0, 0, 0, 0, 1};
    logic       e_busy1 [7] = '{1, 1, 1, 1, 1, 1, 0};
    logic       e_blk1  [7] = '{1, 1, 0, 1, 1, 1, 0};
    logic [5:0] e_sel4  [15] = '{0, 0, 1, 1, 1, 0, 0, 3, 3, 3, 3, 3, 3, 3, 0};
    logic       e_blk6  [7] = '{1, 1, 0, 0, 0, 1, 0};
    bit         found;

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; last_idx = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_sel = '0; cfg_dwell = '0;
    step();
    check("rst_sel", 32'(sel), 0);
    check("rst_idx", 32'(step_idx), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_stb", 32'(step_stb), 0);
    check("rst_done", 32'(done), 0);
    check("rst_blank", 32'(blank), 0);
    rst_n = 1'b1;
    step();

    // Single pass {0,3},{1,1},{2,2}, last=2, no loop.
    wr(0, 0, 3); wr(1, 1, 1); wr(2, 2, 2);
    last_idx = 2; loop_en = 1'b0;
    pulse_start();
    for (int c = 0; c < 7; c++) begin
      if (c > 0) step();
      check($sformatf("p1_sel_c%0d", c + 1), 32'(sel), 32'(e_sel1[c]));
      check($sformatf("p1_idx_c%0d", c + 1), 32'(step_idx), 32'(e_idx1[c]));
      check($sformatf("p1_stb_c%0d", c + 1), 32'(step_stb), 32'(e_stb1[c]));
      check($sformatf("p1_done_c%0d", c + 1), 32'(done), 32'(e_done1[c]));
      check($sformatf("p1_busy_c%0d", c + 1), 32'(busy), 32'(e_busy1[c]));
      check($sformatf("p1_blank_c%0d", c + 1), 32'(blank), 32'(blk(e_blk1[c])));
    end
    step();
    check("p1_done_once", 32'(done), 0);
    check("p1_sel_hold", 32'(sel), 2);

    // Zero dwell on entry 0 and wrap with loop_en.
    wr(0, 0, 0); wr(1, 1, 2);
    last_idx = 1; loop_en = 1'b1;
    pulse_start();
    for (int c = 0; c < 9; c++) begin
      if (c > 0) step();
      check($sformatf("wrap_sel_c%0d", c + 1), 32'(sel), (c % 3 == 0) ? 0 : 1);
      check($sformatf("wrap_stb_c%0d", c + 1), 32'(step_stb), (c % 3 == 2) ? 0 : 1);
      check($sformatf("wrap_done_c%0d", c + 1), 32'(done), 0);
      check($sformatf("wrap_busy_c%0d", c + 1), 32'(busy), 1);
    end
    pulse_stop();
    check("wrap_stop_busy", 32'(busy), 0);
    check("wrap_stop_sel", 32'(sel), 1);
    check("wrap_stop_done", 32'(done), 0);
    check("wrap_stop_blank", 32'(blank), 0);

    // Stop five cycles into a dwell of 10.
    wr(0, 5, 10);
    last_idx = 0; loop_en = 1'b0;
    pulse_start();
    for (int c = 0; c < 4; c++) step();
    check("abort_busy_pre", 32'(busy), 1);
    pulse_stop();
    check("abort_busy", 32'(busy), 0);
    check("abort_sel", 32'(sel), 5);
    check("abort_done", 32'(done), 0);
    for (int c = 0; c < 8; c++) begin
      step();
      check("abort_no_done", 32'(done), 0);
    end

    // start and stop together in IDLE.
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check("ss_busy", 32'(busy), 0);
    check("ss_stb", 32'(step_stb), 0);
    step();
    check("ss_busy2", 32'(busy), 0);

    // Rewrite entry 1 while it is dwelling.
    wr(0, 0, 2); wr(1, 1, 3);
    last_idx = 1; loop_en = 1'b1;
    pulse_start();
    for (int c = 0; c < 15; c++) begin
      check($sformatf("live_sel_c%0d", c + 1), 32'(sel), 32'(e_sel4[c]));
      cfg_we = (c == 2); cfg_addr = 1; cfg_sel = 3; cfg_dwell = 7;
      step();
    end
    cfg_we = 1'b0;

    // Reset during entry 2, then confirm the table is back to {0,1}.
    wr(2, 2, 4);
    pulse_stop();
    last_idx = 2; loop_en = 1'b0;
    pulse_start();
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (step_idx == 2) found = 1'b1;
      else step();
    end
    check("rstrun_reach_e2", 32'(found), 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rstrun_sel", 32'(sel), 0);
    check("rstrun_idx", 32'(step_idx), 0);
    check("rstrun_busy", 32'(busy), 0);
    check("rstrun_stb", 32'(step_stb), 0);
    check("rstrun_done", 32'(done), 0);
    check("rstrun_blank", 32'(blank), 0);
    last_idx = 3; loop_en = 1'b0;
    pulse_start();
    for (int c = 0; c < 5; c++) begin
      if (c > 0) step();
      check($sformatf("clr_sel_c%0d", c + 1), 32'(sel), 0);
      check($sformatf("clr_idx_c%0d", c + 1), 32'(step_idx), (c < 4) ? c : 3);
      check($sformatf("clr_stb_c%0d", c + 1), 32'(step_stb), (c < 4) ? 1 : 0);
      check($sformatf("clr_done_c%0d", c + 1), 32'(done), (c == 4) ? 1 : 0);
    end

    // Blank pattern for dwells 5 and 1.
    wr(0, 0, 5); wr(1, 1, 1);
    last_idx = 1; loop_en = 1'b0;
    pulse_start();
    for (int c = 0; c < 7; c++) begin
      if (c > 0) step();
      check($sformatf("blank_c%0d", c + 1), 32'(blank), 32'(blk(e_blk6[c])));
    end
    check("blank_done", 32'(done), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
